alu_seq: RTL

//   Parametrised, registered successor to the 8-bit combinational ALU, with the same opcode encoding.
//   - Operands/opcode accepted through a valid/ready handshake; the result is held until consumed.
//   - Adds a variable shift amount, SLL, an iterative unsigned multiply and extra flags (overflow, negative, error).
//   - Sits between the operand-load logic (switch/button registers) and the display/result path.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_mul_seq.sv | 41 ++++
 rtl/alu_seq.sv | 100 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by the sequential ALU
package alu_pkg;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand handshake in, result/flags handshake out
interface alu_seq_if #(parameter int BUS = 8, parameter int OP = 6);
  logic [BUS-1:0] a;
  logic [BUS-1:0] b;
  logic [OP-1:0] op;
  logic in_valid;
  logic in_ready;
  logic [BUS-1:0] rdo;
  logic [BUS-1:0] rdo_hi;
  logic carry;
  logic zero;
  logic overflow;
  logic negative;
  logic error;
  logic out_valid;
  logic out_ready;
  modport master (
    output a, b, op, in_valid, out_ready,
    input in_ready, rdo, rdo_hi, carry, zero, overflow, negative, error, out_valid
  );
  modport slave (
    input a, b, op, in_valid, out_ready,
    output in_ready, rdo, rdo_hi, carry, zero, overflow, negative, error, out_valid
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one bit per cycle, done pulses after BUS steps
module alu_mul_seq #(parameter int BUS = 8) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [BUS-1:0] a,
  input  logic [BUS-1:0] b,
  output logic done,
  output logic [2*BUS-1:0] product
);
  localparam int CW = $clog2(BUS) + 1;
  logic [BUS-1:0] m;
  logic [CW-1:0] cnt;
  logic busy;
  function automatic logic [2*BUS-1:0] step(input logic [2*BUS-1:0] p, input logic [BUS-1:0] mc);
    logic [BUS:0] s;
    s = {1'b0, p[2*BUS-1:BUS]} + (p[0] ? {1'b0, mc} : '0);
    return {s, p[BUS-1:1]};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      m <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= busy && cnt == CW'(BUS-1);
      if (start) begin
        product <= step({{BUS{1'b0}}, b}, a);
        m <= a;
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        product <= step(product, m);
        cnt <= cnt + CW'(1);
        busy <= cnt != CW'(BUS-1);
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, shifts, iterative MULTU and extended flags
module alu_seq import alu_pkg::*; #(
  parameter int BUS = 8,
  parameter int OP = 6,
  parameter int SH_W = $clog2(BUS)
) (
  input logic clk,
  input logic reset,
  alu_seq_if.slave bus
);
  state_t state, nxt;
  logic [OP-1:0] op;
  logic [SH_W-1:0] sh;
  logic [BUS:0] add, sub;
  logic [BUS-1:0] res;
  logic c, v, err, acc, is_mul, mul_done;
  logic [2*BUS-1:0] prod;
  assign op = bus.op;
  assign sh = bus.b[SH_W-1:0];
  assign add = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub = {1'b0, bus.a} - {1'b0, bus.b};
  assign is_mul = op == OP_MULTU;
  assign acc = bus.in_valid && state == ST_IDLE;
  assign bus.in_ready = state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  alu_mul_seq #(.BUS(BUS)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(acc && is_mul),
    .a(bus.a),
    .b(bus.b),
    .done(mul_done),
    .product(prod)
  );
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD: begin
        {c, res} = add;
        v = (bus.a[BUS-1] == bus.b[BUS-1]) && (add[BUS-1] != bus.a[BUS-1]);
      end
      OP_SUB: begin
        {c, res} = sub;
        v = (bus.a[BUS-1] != bus.b[BUS-1]) && (sub[BUS-1] != bus.a[BUS-1]);
      end
      OP_AND: res = bus.a & bus.b;
      OP_OR: res = bus.a | bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      OP_NOR: res = ~(bus.a | bus.b);
      OP_SLL: res = bus.a << sh;
      OP_SRL: res = bus.a >> sh;
      OP_SRA: res = BUS'($signed(bus.a) >>> sh);
      OP_MULTU: res = '0;
      default: err = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: nxt = bus.in_valid ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
      ST_BUSY: nxt = mul_done ? ST_DONE : ST_BUSY;
      ST_DONE: nxt = bus.out_ready ? ST_IDLE : ST_DONE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdo <= '0;
      bus.rdo_hi <= '0;
      bus.carry <= 1'b0;
      bus.zero <= 1'b0;
      bus.overflow <= 1'b0;
      bus.negative <= 1'b0;
      bus.error <= 1'b0;
    end else if (acc && !is_mul) begin
      bus.rdo <= res;
      bus.rdo_hi <= '0;
      bus.carry <= c;
      bus.zero <= res == '0 && !err;
      bus.overflow <= v;
      bus.negative <= res[BUS-1];
      bus.error <= err;
    end else if (state == ST_BUSY && mul_done) begin
      bus.rdo <= prod[BUS-1:0];
      bus.rdo_hi <= prod[2*BUS-1:BUS];
      bus.carry <= |prod[2*BUS-1:BUS];
      bus.zero <= prod[BUS-1:0] == '0;
      bus.overflow <= 1'b0;
      bus.negative <= prod[BUS-1];
      bus.error <= 1'b0;
    end
  end
endmodule
